// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a debug/loader master.
// Define DMEM_ARB_STARVE_EN to add the DBG starvation counter and the forced-grant (FORCE) state.
module dmem_arbiter #(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 16,
    parameter int DMEMWORDBITS = 2,
    parameter int STARVEMAX    = 4
) (
    input  logic                                 clk,
    input  logic                                 RESET_N,
    input  logic                                 cpu_req,
    input  logic                                 cpu_we,
    input  logic [DBITS-1:0]                     cpu_addr,
    input  logic [DBITS-1:0]                     cpu_wdata,
    output logic                                 cpu_stall,
    output logic [DBITS-1:0]                     cpu_rdata,
    output logic                                 cpu_rvalid,
    input  logic                                 dbg_req,
    input  logic                                 dbg_we,
    input  logic [DBITS-1:0]                     dbg_addr,
    input  logic [DBITS-1:0]                     dbg_wdata,
    output logic                                 dbg_gnt,
    output logic [DBITS-1:0]                     dbg_rdata,
    output logic                                 dbg_rvalid,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata
);

    logic cpu_io;
    logic cpu_mem;
    logic cpu_gnt;
    logic rd_pend_q;
    logic owner_q;          // 0 = CPU issued the pending read, 1 = DBG
    logic [DBITS-1:0] cpu_rdata_q;
    logic [DBITS-1:0] dbg_rdata_q;
    logic addr_unused;

    // The top 4 KiB page is memory-mapped I/O and never reaches the memory.
    assign cpu_io      = &cpu_addr[DBITS-1:12];
    assign cpu_mem     = cpu_req & ~cpu_io;
    assign addr_unused = ^{cpu_addr[DMEMWORDBITS-1:0], dbg_addr[DBITS-1:DMEMADDRBITS],
                           dbg_addr[DMEMWORDBITS-1:0]};

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_FORCE   = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVEMAX);

    logic [0:0] state_q, state_d;
    logic [3:0] starve_q, starve_d;

    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        cpu_stall = 1'b0;
        state_d   = ST_NORMAL;
        starve_d  = '0;
        if (state_q == ST_FORCE) begin
            dbg_gnt   = dbg_req;
            cpu_stall = cpu_mem;
        end else begin
            cpu_gnt = cpu_mem;
            dbg_gnt = dbg_req & ~cpu_mem;
        end
        if (dbg_req && !dbg_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end
        // FORCE lasts exactly one cycle, so it never chains into another FORCE.
        if (state_q == ST_NORMAL && starve_d == STARVE_LIM) begin
            state_d = ST_FORCE;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
`else
    logic [3:0] starve_unused;

    assign starve_unused = 4'(STARVEMAX);
    assign cpu_gnt       = cpu_mem;
    assign dbg_gnt       = dbg_req & ~cpu_mem;
    assign cpu_stall     = 1'b0;
`endif

    always_comb begin
        mem_en = cpu_gnt | dbg_gnt;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            mem_wdata = dbg_wdata;
        end else begin
            mem_we    = cpu_gnt & cpu_we;
            mem_addr  = cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_rvalid = rd_pend_q & ~owner_q;
    assign dbg_rvalid = rd_pend_q & owner_q;
    // The memory word is on mem_rdata during the return cycle; the _q copies hold it afterwards.
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            rd_pend_q   <= 1'b0;
            owner_q     <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            rd_pend_q <= mem_en & ~mem_we;
            if (mem_en && !mem_we) begin
                owner_q <= dbg_gnt;
            end
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: read returns go through a scoreboard queue,
// grant/stall/memory-side outputs are checked inline by each scenario task.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    typedef struct {
        bit          port;   // 0 = CPU, 1 = DBG
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];
    logic [31:0] last_cpu = '0;
    logic [31:0] last_dbg = '0;

    logic [31:0] wr_val [0:16383];
    bit          wr_vld [0:16383];

    dmem_arbiter #(.DBITS(32), .DMEMADDRBITS(16), .DMEMWORDBITS(2), .STARVEMAX(4)) dut (
        .clk(clk), .RESET_N(RESET_N),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Background memory contents; words written during the run override them.
    function automatic logic [31:0] pat(input logic [13:0] w);
        if (w == 14'd65) return 32'hDEADBEEF;
        if (w == 14'd130) return 32'hCAFEF00D;
        return {16'hA5A5, 2'b00, w};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) begin
                wr_val[mem_addr] <= mem_wdata;
                wr_vld[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_vld[mem_addr] ? wr_val[mem_addr] : pat(mem_addr);
            end
        end
    end

    // Scoreboard consumer: each cycle either the due return appears, or nothing does.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.port == 1'b0) begin
                    if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== e.data || dbg_rdata !== last_dbg) begin
                        n_fail++;
                        $display("FAIL cpu_return cyc=%0d: rvalid c/d=%b/%b rdata c/d=%h/%h, want 1/0 %h/%h",
                                 cyc, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, e.data, last_dbg);
                    end
                    last_cpu = e.data;
                end else begin
                    if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== e.data || cpu_rdata !== last_cpu) begin
                        n_fail++;
                        $display("FAIL dbg_return cyc=%0d: rvalid c/d=%b/%b rdata c/d=%h/%h, want 0/1 %h/%h",
                                 cyc, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, last_cpu, e.data);
                    end
                    last_dbg = e.data;
                end
            end else if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || cpu_rdata !== last_cpu || dbg_rdata !== last_dbg) begin
                n_fail++;
                $display("FAIL idle_return cyc=%0d: rvalid c/d=%b/%b rdata c/d=%h/%h, want 0/0 %h/%h",
                         cyc, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, last_cpu, last_dbg);
            end
        end
    end

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        RESET_N = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cpu_rvalid, dbg_rvalid, cpu_stall, dbg_gnt, mem_en} !== 5'b0 || cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: rv c/d=%b/%b stall=%b gnt=%b en=%b rdata c/d=%h/%h, want all 0",
                     cpu_rvalid, dbg_rvalid, cpu_stall, dbg_gnt, mem_en, cpu_rdata, dbg_rdata);
        end
        $display("txn reset released");
        RESET_N = 1'b1;
    endtask

    task automatic test_cpu_load();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0104;
        #1;
        n_checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'd65 || cpu_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_load_issue: en=%b we=%b addr=%0d stall=%b gnt=%b, want 1 0 65 0 0",
                     mem_en, mem_we, mem_addr, cpu_stall, dbg_gnt);
        end
        sb_q.push_back('{1'b0, 32'hDEADBEEF, cyc + 1});
        $display("txn cpu load addr=%h", cpu_addr);
        next_cycle();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'((10 + i) * 4);
            #1;
            n_checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'(10 + i) || cpu_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_issue i=%0d: en=%b we=%b addr=%0d stall=%b, want 1 0 %0d 0",
                         i, mem_en, mem_we, mem_addr, cpu_stall, 10 + i);
            end
            sb_q.push_back('{1'b0, pat(14'(10 + i)), cyc + 1});
            $display("txn cpu load addr=%h (streamed)", cpu_addr);
            next_cycle();
        end
        idle();
    endtask

    task automatic test_io_bypass();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_F020; cpu_wdata = 32'h0000_0003;
        #1;
        n_checks++;
        if (mem_en !== 1'b0 || cpu_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL io_store: en=%b stall=%b gnt=%b, want 0 0 0", mem_en, cpu_stall, dbg_gnt);
        end
        $display("txn cpu io store addr=%h", cpu_addr);
        next_cycle();
        cpu_we = 1'b0; cpu_addr = 32'hFFFF_F000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'hABCD_0104;
        #1;
        n_checks++;
        if (dbg_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'd65 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL io_load_dbg: gnt=%b en=%b we=%b addr=%0d stall=%b, want 1 1 0 65 0",
                     dbg_gnt, mem_en, mem_we, mem_addr, cpu_stall);
        end
        sb_q.push_back('{1'b1, 32'hDEADBEEF, cyc + 1});
        $display("txn cpu io load + dbg load addr=%h", dbg_addr);
        next_cycle();
        idle();
    endtask

    task automatic test_writes();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0000_0200; dbg_wdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (dbg_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 14'd128 || mem_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL dbg_write: gnt=%b en=%b we=%b addr=%0d wdata=%h, want 1 1 1 128 12345678",
                     dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        $display("txn dbg store addr=%h data=%h", dbg_addr, dbg_wdata);
        next_cycle();
        idle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0300; cpu_wdata = 32'h0BAD_CAFE;
        #1;
        n_checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 14'd192 || mem_wdata !== 32'h0BAD_CAFE || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_write: en=%b we=%b addr=%0d wdata=%h stall=%b, want 1 1 192 0badcafe 0",
                     mem_en, mem_we, mem_addr, mem_wdata, cpu_stall);
        end
        $display("txn cpu store addr=%h data=%h", cpu_addr, cpu_wdata);
        next_cycle();
        cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
        #1;
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 14'd128) begin
            n_fail++;
            $display("FAIL cpu_readback_issue: en=%b addr=%0d, want 1 128", mem_en, mem_addr);
        end
        sb_q.push_back('{1'b0, 32'h1234_5678, cyc + 1});
        $display("txn cpu load addr=%h", cpu_addr);
        next_cycle();
        idle();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h7700_0300;
        #1;
        n_checks++;
        if (dbg_gnt !== 1'b1 || mem_addr !== 14'd192) begin
            n_fail++;
            $display("FAIL dbg_readback_issue: gnt=%b addr=%0d, want 1 192", dbg_gnt, mem_addr);
        end
        sb_q.push_back('{1'b1, 32'h0BAD_CAFE, cyc + 1});
        $display("txn dbg load addr=%h", dbg_addr);
        next_cycle();
        idle();
    endtask

    // CPU loads every cycle while DBG waits for a read; optional reset edge mid-wait and
    // optional DBG withdrawal in the cycle it would have been granted.
    task automatic test_starvation(input int reset_at, input bit drop);
        int base, g, cpu_end, last;
        bit exp_gnt, exp_stall, exp_en;
        base    = (reset_at < 0) ? 4 : reset_at + 5;
        g       = STARVE ? base : base + 2;
        last    = g + 2;
        cpu_end = STARVE ? last + 1 : g;
        for (int c = 0; c <= last; c++) begin
            RESET_N  = (c != reset_at);
            cpu_req  = (c < cpu_end); cpu_we = 1'b0; cpu_addr = 32'h0000_0104;
            dbg_req  = (c < g) || (c == g && !drop); dbg_we = 1'b0; dbg_addr = 32'h0000_0208;
            exp_gnt   = (c == g) && !drop;
            exp_stall = STARVE && (c == g) && cpu_req;
            exp_en    = exp_gnt || (cpu_req && !exp_stall);
            #1;
            n_checks++;
            if (dbg_gnt !== exp_gnt || cpu_stall !== exp_stall || mem_en !== exp_en) begin
                n_fail++;
                $display("FAIL starve r=%0d d=%0d c=%0d: gnt=%b stall=%b en=%b, want %b %b %b",
                         reset_at, drop, c, dbg_gnt, cpu_stall, mem_en, exp_gnt, exp_stall, exp_en);
            end
            if (exp_en) begin
                n_checks++;
                if (mem_addr !== (exp_gnt ? 14'd130 : 14'd65)) begin
                    n_fail++;
                    $display("FAIL starve_addr r=%0d c=%0d: addr=%0d, want %0d",
                             reset_at, c, mem_addr, exp_gnt ? 130 : 65);
                end
            end
            if (c != reset_at) begin
                if (exp_gnt) sb_q.push_back('{1'b1, 32'hCAFEF00D, cyc + 1});
                else if (exp_en) sb_q.push_back('{1'b0, 32'hDEADBEEF, cyc + 1});
            end
            $display("txn starve r=%0d d=%0d c=%0d cpu_req=%b dbg_req=%b rst_n=%b",
                     reset_at, drop, c, cpu_req, dbg_req, RESET_N);
            next_cycle();
            if (c == reset_at) begin
                last_cpu = '0;
                last_dbg = '0;
                n_checks++;
                if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_discard: rvalid=%b rdata=%h, want 0 00000000", cpu_rvalid, cpu_rdata);
                end
            end
        end
        RESET_N = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_cpu_load();
        test_back_to_back();
        test_io_bypass();
        test_writes();
        test_starvation(-1, 1'b0);
        test_starvation(-1, 1'b1);
        test_starvation(2, 1'b0);
        next_cycle();
        next_cycle();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d returns outstanding, want 0", sb_q.size());
        end
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
